// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer and 3-byte movement packet framer.
// Drives reset (0xFF) and enable-reporting (0xF4) through the byte transmitter,
// checks the mouse responses, retries on faults, then frames stream packets.
module ps2_mouse_init_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       cmd_ready,
  input  logic       cmd_sent,
  input  logic       cmd_error,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       send_cmd,
  output logic [7:0] cmd_byte,
  output logic       init_done,
  output logic       init_fail,
  output logic       pkt_valid,
  output logic [2:0] pkt_buttons,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy,
  output logic [1:0] pkt_ovf,
  output logic [3:0] state_dbg
);

  localparam int unsigned RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
  localparam logic [7:0] RSP_ID      = 8'h00;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    SEND_RST     = 4'd1,
    WAIT_TX_RST  = 4'd2,
    WAIT_ACK_RST = 4'd3,
    WAIT_BAT     = 4'd4,
    WAIT_ID      = 4'd5,
    SEND_EN      = 4'd6,
    WAIT_TX_EN   = 4'd7,
    WAIT_ACK_EN  = 4'd8,
    STREAM       = 4'd9,
    FAIL         = 4'd10
  } state_t;

  state_t           r_state;
  logic             r_send_cmd;
  logic [7:0]       r_cmd_byte;
  logic             r_init_done;
  logic             r_init_fail;
  logic             r_pkt_valid;
  logic [2:0]       r_pkt_buttons;
  logic [8:0]       r_pkt_dx;
  logic [8:0]       r_pkt_dy;
  logic [1:0]       r_pkt_ovf;
  logic [RW-1:0]    r_retry_cnt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [1:0]       r_byte_idx;
  logic [3:0]       r_b0_hi;
  logic [2:0]       r_b0_btn;
  logic [7:0]       r_b1;

  logic             w_is_wait;
  logic             w_adv;
  state_t           w_adv_state;
  logic             w_retry;
  state_t           w_retry_state;
  logic [RW-1:0]    w_retry_inc;
  logic             w_retry_fail;

  // Wait-state decode: handshake/response advance, retry on fault, resend or timeout
  always_comb begin
    w_is_wait     = 1'b1;
    w_adv         = 1'b0;
    w_adv_state   = r_state;
    w_retry       = 1'b0;
    w_retry_state = SEND_RST;
    case (r_state)
      WAIT_TX_RST: begin
        if (cmd_sent) begin
          w_adv       = 1'b1;
          w_adv_state = WAIT_ACK_RST;
        end else if (cmd_error) begin
          w_retry = 1'b1;
        end
      end
      WAIT_ACK_RST: begin
        if (rx_valid && rx_byte == RSP_ACK) begin
          w_adv       = 1'b1;
          w_adv_state = WAIT_BAT;
        end
      end
      WAIT_BAT: begin
        if (rx_valid && rx_byte == RSP_BAT_OK) begin
          w_adv       = 1'b1;
          w_adv_state = WAIT_ID;
        end else if (rx_valid && rx_byte == RSP_BAT_ERR) begin
          w_retry = 1'b1;
        end
      end
      WAIT_ID: begin
        if (rx_valid && rx_byte == RSP_ID) begin
          w_adv       = 1'b1;
          w_adv_state = SEND_EN;
        end
      end
      WAIT_TX_EN: begin
        if (cmd_sent) begin
          w_adv       = 1'b1;
          w_adv_state = WAIT_ACK_EN;
        end else if (cmd_error) begin
          w_retry = 1'b1;
        end
      end
      WAIT_ACK_EN: begin
        if (rx_valid && rx_byte == RSP_ACK) begin
          w_adv       = 1'b1;
          w_adv_state = STREAM;
        end
      end
      default: w_is_wait = 1'b0;
    endcase
    // Resend request repeats the command currently in flight
    if (w_is_wait && !w_adv && !w_retry && rx_valid && rx_byte == RSP_RESEND) begin
      w_retry       = 1'b1;
      w_retry_state = (r_state == WAIT_TX_EN || r_state == WAIT_ACK_EN) ? SEND_EN : SEND_RST;
    end
    // A received byte always beats timeout expiry in the same cycle
    if (w_is_wait && !w_adv && !w_retry && !rx_valid && r_tmo_cnt == TMO_LAST) begin
      w_retry = 1'b1;
    end
  end

  // Saturating retry count and the give-up decision
  assign w_retry_inc  = (r_retry_cnt == RETRY_MAX) ? r_retry_cnt : r_retry_cnt + RW'(1);
  assign w_retry_fail = (w_retry_inc == RETRY_MAX);

  // Main FSM, timeout counter, packet framer and registered outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_send_cmd    <= 1'b0;
      r_cmd_byte    <= 8'h00;
      r_init_done   <= 1'b0;
      r_init_fail   <= 1'b0;
      r_pkt_valid   <= 1'b0;
      r_pkt_buttons <= 3'b000;
      r_pkt_dx      <= 9'h000;
      r_pkt_dy      <= 9'h000;
      r_pkt_ovf     <= 2'b00;
      r_retry_cnt   <= '0;
      r_tmo_cnt     <= '0;
      r_byte_idx    <= 2'd0;
      r_b0_hi       <= 4'h0;
      r_b0_btn      <= 3'b000;
      r_b1          <= 8'h00;
    end else begin
      r_send_cmd  <= 1'b0;
      r_pkt_valid <= 1'b0;
      if (w_is_wait) begin
        if (w_retry) begin
          r_retry_cnt <= w_retry_inc;
          r_tmo_cnt   <= '0;
          if (w_retry_fail) begin
            r_state     <= FAIL;
            r_init_fail <= 1'b1;
          end else begin
            r_state    <= w_retry_state;
            r_cmd_byte <= (w_retry_state == SEND_EN) ? CMD_ENABLE : CMD_RESET;
          end
        end else if (w_adv) begin
          r_state   <= w_adv_state;
          r_tmo_cnt <= '0;
          if (w_adv_state == SEND_EN) begin
            r_cmd_byte <= CMD_ENABLE;
          end
          if (w_adv_state == STREAM) begin
            r_init_done <= 1'b1;
            r_byte_idx  <= 2'd0;
          end
        end else if (rx_valid) begin
          r_tmo_cnt <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
      end else begin
        case (r_state)
          IDLE, FAIL: begin
            if (start) begin
              r_state     <= SEND_RST;
              r_cmd_byte  <= CMD_RESET;
              r_retry_cnt <= '0;
              r_init_fail <= 1'b0;
              r_tmo_cnt   <= '0;
            end
          end
          SEND_RST: begin
            if (cmd_ready) begin
              r_send_cmd <= 1'b1;
              r_state    <= WAIT_TX_RST;
            end
          end
          SEND_EN: begin
            if (cmd_ready) begin
              r_send_cmd <= 1'b1;
              r_state    <= WAIT_TX_EN;
            end
          end
          STREAM: begin
            if (rx_valid) begin
              case (r_byte_idx)
                2'd0: begin
                  // Bit 3 is always set in a header byte; anything else is dropped to resync
                  if (rx_byte[3]) begin
                    r_b0_hi    <= rx_byte[7:4];
                    r_b0_btn   <= rx_byte[2:0];
                    r_byte_idx <= 2'd1;
                  end
                end
                2'd1: begin
                  r_b1       <= rx_byte;
                  r_byte_idx <= 2'd2;
                end
                default: begin
                  r_byte_idx    <= 2'd0;
                  r_pkt_valid   <= 1'b1;
                  r_pkt_buttons <= r_b0_btn;
                  r_pkt_dx      <= {r_b0_hi[0], r_b1};
                  r_pkt_dy      <= {r_b0_hi[1], rx_byte};
                  r_pkt_ovf     <= {r_b0_hi[3], r_b0_hi[2]};
                end
              endcase
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign send_cmd    = r_send_cmd;
  assign cmd_byte    = r_cmd_byte;
  assign init_done   = r_init_done;
  assign init_fail   = r_init_fail;
  assign pkt_valid   = r_pkt_valid;
  assign pkt_buttons = r_pkt_buttons;
  assign pkt_dx      = r_pkt_dx;
  assign pkt_dy      = r_pkt_dy;
  assign pkt_ovf     = r_pkt_ovf;
  assign state_dbg   = r_state;

endmodule
